// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, stability-counter debounce FSM,
// registered press/release/long-press pulses and a press-toggled level.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 10,
   parameter int unsigned LONG_CYCLES     = 40,
   parameter int unsigned CNT_W           = 32
) (
   input  logic clock,
   input  logic reset,
   input  logic button_in,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press,
   output logic toggle
);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_CHK,
      HELD,
      RELEASE_CHK
   } state_e;

   // deb_cnt counts the samples already seen at the new level, so acceptance
   // happens when the current sample is the DEBOUNCE_CYCLES-th one.
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_e           state_q, state_d;
   logic             s1_q, s2_q;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             pressed_q, pressed_d;
   logic             press_pulse_q, press_pulse_d;
   logic             release_pulse_q, release_pulse_d;
   logic             long_press_q, long_press_d;
   logic             toggle_q, toggle_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q            <= 1'b0;
         s2_q            <= 1'b0;
         state_q         <= RELEASED;
         deb_cnt_q       <= '0;
         hold_cnt_q      <= '0;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_press_q    <= 1'b0;
         toggle_q        <= 1'b0;
      end else begin
         s1_q            <= button_in;
         s2_q            <= s1_q;
         state_q         <= state_d;
         deb_cnt_q       <= deb_cnt_d;
         hold_cnt_q      <= hold_cnt_d;
         pressed_q       <= pressed_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         long_press_q    <= long_press_d;
         toggle_q        <= toggle_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      deb_cnt_d       = deb_cnt_q;
      hold_cnt_d      = hold_cnt_q;
      pressed_d       = pressed_q;
      toggle_d        = toggle_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      long_press_d    = 1'b0;

      // Hold timer runs through release glitches; saturation gives one long_press per press.
      if ((state_q == HELD || state_q == RELEASE_CHK) && hold_cnt_q != LONG_MAX) begin
         hold_cnt_d = hold_cnt_q + ONE;
         if (hold_cnt_q + ONE == LONG_MAX) begin
            long_press_d = 1'b1;
         end
      end

      case (state_q)
         RELEASED: begin
            if (s2_q) begin
               if (DEB_LAST == '0) begin
                  state_d       = HELD;
                  deb_cnt_d     = '0;
                  hold_cnt_d    = '0;
                  pressed_d     = 1'b1;
                  press_pulse_d = 1'b1;
                  toggle_d      = ~toggle_q;
               end else begin
                  state_d   = PRESS_CHK;
                  deb_cnt_d = ONE;
               end
            end
         end
         PRESS_CHK: begin
            if (!s2_q) begin
               state_d   = RELEASED;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d       = HELD;
               deb_cnt_d     = '0;
               hold_cnt_d    = '0;
               pressed_d     = 1'b1;
               press_pulse_d = 1'b1;
               toggle_d      = ~toggle_q;
            end else begin
               deb_cnt_d = deb_cnt_q + ONE;
            end
         end
         HELD: begin
            if (!s2_q) begin
               if (DEB_LAST == '0) begin
                  state_d         = RELEASED;
                  deb_cnt_d       = '0;
                  pressed_d       = 1'b0;
                  release_pulse_d = 1'b1;
               end else begin
                  state_d   = RELEASE_CHK;
                  deb_cnt_d = ONE;
               end
            end
         end
         RELEASE_CHK: begin
            if (s2_q) begin
               state_d   = HELD;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d         = RELEASED;
               deb_cnt_d       = '0;
               pressed_d       = 1'b0;
               release_pulse_d = 1'b1;
            end else begin
               deb_cnt_d = deb_cnt_q + ONE;
            end
         end
         default: begin
            state_d   = RELEASED;
            deb_cnt_d = '0;
         end
      endcase
   end

   assign pressed       = pressed_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign long_press    = long_press_q;
   assign toggle        = toggle_q;

endmodule
